sobel_grad: RTL and testbench

//  Sobel gradient stage of the edge pipeline, directly downstream of the 5x5 Gaussian smoother.

---
 rtl/sobel_grad.sv | 185 ++++++++++++++++++
 tb/tb_sobel_grad.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sobel_grad.sv
// Sobel gradient stage: 3x3 window over a raster gray stream, signed Gx/Gy,
// L1 magnitude and a 2-bit quantised edge direction for every interior pixel.
module sobel_grad #(
   parameter int IMG_W = 1024,
   parameter int IMG_H = 1024,
   parameter int CW    = 11
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [7:0]           pix_in,
   input  logic                 pix_valid,
   input  logic                 pix_sof,
   output logic signed [10:0]   gx_out,
   output logic signed [10:0]   gy_out,
   output logic [10:0]          mag_out,
   output logic [1:0]           dir_out,
   output logic                 out_valid,
   output logic [CW-1:0]        out_x,
   output logic [CW-1:0]        out_y,
   output logic                 out_eof
);

   localparam int            AW       = (IMG_W > 1) ? $clog2(IMG_W) : 1;
   localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
   localparam logic [CW-1:0] ROW_LAST = CW'(IMG_H - 1);
   localparam logic [CW-1:0] ONE      = CW'(1);
   localparam logic [CW-1:0] TWO      = CW'(2);

   // Zero-extend a pixel into the signed gradient domain.
   function automatic logic signed [10:0] px(input logic [7:0] p);
      return $signed({3'b000, p});
   endfunction

   function automatic logic [10:0] abs_val(input logic signed [10:0] v);
      return v[10] ? $unsigned(-v) : $unsigned(v);
   endfunction

   // Direction bins: tan(22.5deg)~106/256 and tan(67.5deg)~618/256.
   // Products need 20 bits since |G| can reach 1020 and 1020*618 > 2^19.
   function automatic logic [1:0] quant_dir(input logic signed [10:0] gx,
                                            input logic signed [10:0] gy);
      logic [10:0] ax;
      logic [10:0] ay;
      logic [19:0] ay_s;
      logic [19:0] ax_lo;
      logic [19:0] ax_hi;
      ax    = abs_val(gx);
      ay    = abs_val(gy);
      ay_s  = {1'b0, ay, 8'd0};
      ax_lo = 20'(ax) * 20'd106;
      ax_hi = 20'(ax) * 20'd618;
      if (ay_s <= ax_lo)
         return 2'd0;
      else if (ay_s >= ax_hi)
         return 2'd2;
      else if ((gx > 11'sd0) == (gy > 11'sd0))
         return 2'd1;
      else
         return 2'd3;
   endfunction

   logic [7:0]          lb1 [IMG_W];
   logic [7:0]          lb2 [IMG_W];
   logic [CW-1:0]       col_r, row_r, col_e, row_e;
   logic [AW-1:0]       addr;
   logic [7:0]          lb1_rd, lb2_rd;
   logic [7:0]          w [3][3];
   logic                vld_p0, eof_p0;
   logic [CW-1:0]       x_p0, y_p0;
   logic signed [10:0]  gx_c, gy_c;
   logic signed [10:0]  gx_p1, gy_p1;
   logic                vld_p1, eof_p1;
   logic [CW-1:0]       x_p1, y_p1;

   // Effective position of the incoming pixel (sof resyncs to origin) and line-buffer reads.
   always_comb begin
      col_e  = pix_sof ? '0 : col_r;
      row_e  = pix_sof ? '0 : row_r;
      addr   = col_e[AW-1:0];
      lb1_rd = lb1[addr];
      lb2_rd = lb2[addr];
   end

   // Line buffers shift one row down per accepted pixel; contents survive reset.
   always_ff @(posedge clk) begin
      if (pix_valid) begin
         lb2[addr] <= lb1_rd;
         lb1[addr] <= pix_in;
      end
   end

   // ---- stage 0: raster counters, window shift, interior qualification ----
   // Raster counters, 3x3 window load and stage-0 valid on each accepted pixel.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         col_r  <= '0;
         row_r  <= '0;
         vld_p0 <= 1'b0;
         eof_p0 <= 1'b0;
         x_p0   <= '0;
         y_p0   <= '0;
         for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
               w[r][c] <= 8'd0;
      end else begin
         vld_p0 <= 1'b0;
         eof_p0 <= 1'b0;
         if (pix_valid) begin
            if (col_e == COL_LAST) begin
               col_r <= '0;
               row_r <= (row_e == ROW_LAST) ? '0 : row_e + ONE;
            end else begin
               col_r <= col_e + ONE;
               row_r <= row_e;
            end
            for (int r = 0; r < 3; r++) begin
               w[r][0] <= w[r][1];
               w[r][1] <= w[r][2];
            end
            w[0][2] <= lb2_rd;
            w[1][2] <= lb1_rd;
            w[2][2] <= pix_in;
            vld_p0  <= (row_e >= TWO) && (col_e >= TWO);
            eof_p0  <= (row_e == ROW_LAST) && (col_e == COL_LAST);
            x_p0    <= col_e - ONE;
            y_p0    <= row_e - ONE;
         end
      end
   end

   // ---- stage 1: Sobel kernels ----
   // Kernel sums; worst case 4*255 fits 11-bit signed.
   always_comb begin
      gx_c = (px(w[0][2]) + (px(w[1][2]) <<< 1) + px(w[2][2]))
           - (px(w[0][0]) + (px(w[1][0]) <<< 1) + px(w[2][0]));
      gy_c = (px(w[2][0]) + (px(w[2][1]) <<< 1) + px(w[2][2]))
           - (px(w[0][0]) + (px(w[0][1]) <<< 1) + px(w[0][2]));
   end

   // Stage-1 data registers (no reset needed, qualified by vld_p1).
   always_ff @(posedge clk) begin
      gx_p1 <= gx_c;
      gy_p1 <= gy_c;
      x_p1  <= x_p0;
      y_p1  <= y_p0;
   end

   // Stage-1 valid and end-of-frame flag travel with the data.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_p1 <= 1'b0;
         eof_p1 <= 1'b0;
      end else begin
         vld_p1 <= vld_p0;
         eof_p1 <= vld_p0 & eof_p0;
      end
   end

   // ---- stage 2: magnitude, direction, output registers ----
   // Outputs update only on a valid result and otherwise hold; eof drops with valid.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         gx_out    <= '0;
         gy_out    <= '0;
         mag_out   <= '0;
         dir_out   <= '0;
         out_valid <= 1'b0;
         out_x     <= '0;
         out_y     <= '0;
         out_eof   <= 1'b0;
      end else begin
         out_valid <= vld_p1;
         out_eof   <= vld_p1 & eof_p1;
         if (vld_p1) begin
            gx_out  <= gx_p1;
            gy_out  <= gy_p1;
            mag_out <= abs_val(gx_p1) + abs_val(gy_p1);
            dir_out <= quant_dir(gx_p1, gy_p1);
            out_x   <= x_p1;
            out_y   <= y_p1;
         end
      end
   end

endmodule

// File: tb/tb_sobel_grad.sv
// Bench for sobel_grad on an 8x6 image: image-level reference model with a
// per-cycle output compare, plus literal expectations for each test image.
module tb_sobel_grad;

   localparam int W  = 8;
   localparam int H  = 6;
   localparam int CW = 11;

   logic                clk = 1'b0;
   logic                rst;
   logic [7:0]          pix_in;
   logic                pix_valid;
   logic                pix_sof;
   logic signed [10:0]  gx_out, gy_out;
   logic [10:0]         mag_out;
   logic [1:0]          dir_out;
   logic                out_valid, out_eof;
   logic [CW-1:0]       out_x, out_y;

   sobel_grad #(.IMG_W(W), .IMG_H(H), .CW(CW)) dut (
      .clk(clk), .rst(rst), .pix_in(pix_in), .pix_valid(pix_valid), .pix_sof(pix_sof),
      .gx_out(gx_out), .gy_out(gy_out), .mag_out(mag_out), .dir_out(dir_out),
      .out_valid(out_valid), .out_x(out_x), .out_y(out_y), .out_eof(out_eof)
   );

   always #5 clk = ~clk;

   typedef struct {
      int t; int gx; int gy; int mag; int dir; int x; int y; int eof;
   } exp_t;

   exp_t q[$];
   int   n_chk = 0;
   int   n_fail = 0;
   int   cyc = 0;
   int   img [H][W];
   int   mcol = 0;
   int   mrow = 0;
   int   n_out, n_eof, eof_x, eof_y;
   int   cap_gx [W][H];
   int   cap_gy [W][H];
   int   cap_mag [W][H];
   int   cap_dir [W][H];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic signed [63:0] act,
                      input logic signed [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic int pix_of(input int kind, input int x, input int y);
      case (kind)
         0: return 50;
         1: return (x >= 4) ? 100 : 0;
         2: return (y >= 3) ? 255 : 0;
         3: return (x + y) * 10;
         default: return (x - y + 10) * 10;
      endcase
   endfunction

   function automatic int iabs(input int v);
      return (v < 0) ? -v : v;
   endfunction

   function automatic int dir_of(input int gx, input int gy);
      int ax, ay;
      ax = iabs(gx);
      ay = iabs(gy);
      if (ay * 256 <= ax * 106) return 0;
      if (ay * 256 >= ax * 618) return 2;
      if ((gx > 0) == (gy > 0)) return 1;
      return 3;
   endfunction

   // Reference model and per-cycle compare, sampled on the falling edge.
   initial begin
      exp_t e;
      bit   exp_v;
      int   c, r, gx, gy;
      forever begin
         @(negedge clk);
         if (rst) begin
            q.delete();
            mcol = 0;
            mrow = 0;
            chk("valid_in_reset", out_valid, 0);
         end else begin
            exp_v = (q.size() > 0) && (q[0].t == cyc);
            chk("out_valid", out_valid, exp_v);
            if (exp_v) begin
               e = q.pop_front();
               chk("gx", gx_out, e.gx);
               chk("gy", gy_out, e.gy);
               chk("mag", mag_out, e.mag);
               chk("dir", dir_out, e.dir);
               chk("x", out_x, e.x);
               chk("y", out_y, e.y);
               chk("eof", out_eof, e.eof);
            end else begin
               chk("eof_idle", out_eof, 0);
            end
            if (out_valid && out_x < W && out_y < H) begin
               n_out++;
               cap_gx[out_x][out_y]  = gx_out;
               cap_gy[out_x][out_y]  = gy_out;
               cap_mag[out_x][out_y] = mag_out;
               cap_dir[out_x][out_y] = dir_out;
               if (out_eof) begin
                  n_eof++;
                  eof_x = out_x;
                  eof_y = out_y;
               end
            end
            if (pix_valid) begin
               c = pix_sof ? 0 : mcol;
               r = pix_sof ? 0 : mrow;
               img[r][c] = pix_in;
               if (r >= 2 && c >= 2) begin
                  gx = (img[r-2][c] + 2*img[r-1][c] + img[r][c])
                     - (img[r-2][c-2] + 2*img[r-1][c-2] + img[r][c-2]);
                  gy = (img[r][c-2] + 2*img[r][c-1] + img[r][c])
                     - (img[r-2][c-2] + 2*img[r-2][c-1] + img[r-2][c]);
                  e.t = cyc + 3; e.gx = gx; e.gy = gy;
                  e.mag = iabs(gx) + iabs(gy); e.dir = dir_of(gx, gy);
                  e.x = c - 1; e.y = r - 1;
                  e.eof = (c == W-1 && r == H-1) ? 1 : 0;
                  q.push_back(e);
               end
               mcol = (c == W-1) ? 0 : c + 1;
               mrow = (c == W-1) ? ((r == H-1) ? 0 : r + 1) : r;
            end
         end
      end
   end

   task automatic clear_cap();
      n_out = 0; n_eof = 0; eof_x = -1; eof_y = -1;
      for (int x = 0; x < W; x++)
         for (int y = 0; y < H; y++) begin
            cap_gx[x][y] = -9999; cap_gy[x][y] = -9999;
            cap_mag[x][y] = -9999; cap_dir[x][y] = -9999;
         end
   endtask

   task automatic send_frame(input int kind, input bit gaps, input int npix);
      for (int i = 0; i < npix; i++) begin
         if (gaps) begin
            int k;
            k = $urandom_range(2, 0);
            for (int j = 0; j < k; j++) begin
               @(posedge clk); #1;
               pix_valid = 1'b0; pix_sof = 1'b0;
            end
         end
         @(posedge clk); #1;
         pix_valid = 1'b1;
         pix_sof   = (i == 0);
         pix_in    = 8'(pix_of(kind, i % W, i / W));
      end
      @(posedge clk); #1;
      pix_valid = 1'b0;
      pix_sof   = 1'b0;
   endtask

   task automatic flush();
      repeat (6) @(negedge clk);
   endtask

   initial begin
      rst = 1'b1; pix_valid = 1'b0; pix_sof = 1'b0; pix_in = 8'd0;
      for (int y = 0; y < H; y++)
         for (int x = 0; x < W; x++)
            img[y][x] = 0;
      clear_cap();
      repeat (3) @(negedge clk);
      chk("rst_gx", gx_out, 0);
      chk("rst_gy", gy_out, 0);
      chk("rst_mag", mag_out, 0);
      chk("rst_dir", dir_out, 0);
      chk("rst_xy", {out_x, out_y}, 0);
      chk("rst_eof", out_eof, 0);
      @(posedge clk); #1 rst = 1'b0;

      // T1 uniform
      clear_cap(); send_frame(0, 1'b0, W*H); flush();
      chk("t1_count", n_out, 24);
      chk("t1_eofs", n_eof, 1);
      chk("t1_eof_x", eof_x, 6);
      chk("t1_eof_y", eof_y, 4);
      chk("t1_mag", cap_mag[3][2], 0);
      chk("t1_dir", cap_dir[6][4], 0);

      // T2 vertical step
      clear_cap(); send_frame(1, 1'b0, W*H); flush();
      chk("t2_gx_3", cap_gx[3][2], 400);
      chk("t2_gx_4", cap_gx[4][3], 400);
      chk("t2_gy", cap_gy[3][2], 0);
      chk("t2_mag", cap_mag[4][2], 400);
      chk("t2_dir", cap_dir[3][2], 0);
      chk("t2_flat_l", cap_mag[2][2], 0);
      chk("t2_flat_r", cap_mag[5][4], 0);

      // T3 horizontal step
      clear_cap(); send_frame(2, 1'b0, W*H); flush();
      chk("t3_gy_2", cap_gy[3][2], 1020);
      chk("t3_gy_3", cap_gy[5][3], 1020);
      chk("t3_gx", cap_gx[3][2], 0);
      chk("t3_mag", cap_mag[1][3], 1020);
      chk("t3_dir", cap_dir[3][2], 2);
      chk("t3_flat_t", cap_mag[3][1], 0);
      chk("t3_flat_b", cap_mag[3][4], 0);

      // T4 diagonals
      clear_cap(); send_frame(3, 1'b0, W*H); flush();
      chk("t4a_gx", cap_gx[2][2], 80);
      chk("t4a_gy", cap_gy[2][2], 80);
      chk("t4a_mag", cap_mag[2][2], 160);
      chk("t4a_dir", cap_dir[2][2], 1);
      clear_cap(); send_frame(4, 1'b0, W*H); flush();
      chk("t4b_gx", cap_gx[4][3], 80);
      chk("t4b_gy", cap_gy[4][3], -80);
      chk("t4b_mag", cap_mag[4][3], 160);
      chk("t4b_dir", cap_dir[4][3], 3);

      // T5 vertical step with random input gaps
      clear_cap(); send_frame(1, 1'b1, W*H); flush();
      chk("t5_count", n_out, 24);
      chk("t5_gx", cap_gx[4][1], 400);
      chk("t5_flat", cap_mag[1][1], 0);
      chk("t5_eofs", n_eof, 1);

      // T6 reset mid row 3, then a fresh uniform frame
      send_frame(1, 1'b0, 3*W + 3);
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      clear_cap(); send_frame(0, 1'b0, W*H); flush();
      chk("t6_count", n_out, 24);
      chk("t6_eofs", n_eof, 1);
      chk("t6_mag", cap_mag[3][2], 0);
      chk("t6_gx", cap_gx[4][1], 0);

      for (int i = 0; i < 20 && q.size() > 0; i++) @(negedge clk);
      chk("drain", q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
